text_banner: RTL and testbench
==============================

// Module: text_banner
// PURPOSE
//   Parametrised on-screen text overlay: renders a runtime-writable string of 7x7 glyphs at a
//   fixed screen position, optionally scaled by 1x/2x/4x, with static, blink, typewriter-reveal
//   or reveal-then-blink modes. Sits beside the other sprite/overlay layers in the VGA pixel
//   path and feeds the colour mux. Pixel output is pipelined (2 cycles) and registered.
// PARAMETERS
//   POS_X        8       left edge of string box, screen columns
//   POS_Y        8       top edge of string box, screen rows
//   MAX_CHARS    16      character buffer depth (power of 2, 2..32)
//   SCALE_LOG2   0       glyph magnification 2**SCALE_LOG2, legal 0..2
//   COLOR        12'hFFF RGB444 colour of lit pixels
//   BLINK_FRAMES 30      frames per blink phase (visible / hidden)
//   TYPE_FRAMES  4       frames between successive revealed characters
// PORTS
//   clk          in   1   pixel clock
//   rst_n        in   1   reset, asynchronous, active-low
//   col          in   10  current scan column
//   row          in   10  current scan row
//   frame_tick   in   1   one-cycle pulse at start of each frame
//   wr_en        in   1   write wr_data into char buffer at wr_addr
//   wr_addr      in   AW  buffer index, AW = clog2(MAX_CHARS)
//   wr_data      in   5   char code: 0 = space, 1..26 = A..Z, 27..31 = blank
//   start        in   1   latch len/mode, restart reveal and blink
//   len          in   6   string length, sampled on start
//   mode         in   2   00 static, 01 blink, 10 typewriter, 11 typewriter then blink
//   is_text      out  1   lit text pixel at (col,row) presented 2 cycles earlier
//   text_rgb     out  12  COLOR when is_text, else 12'h000
//   reveal_done  out  1   high while reveal_cnt == len_q
// BEHAVIOUR
//   Reset: char buffer all 0 (space); len_q=0, mode_q=00, reveal_cnt=0, frame counters=0,
//     blink_vis=1; is_text=0, text_rgb=0; reveal_done=1 (0==0). Reset mid-frame clears at once.
//   Geometry: cell = 8 cols x 7 rows (glyph in cell cols 0..6, col 7 always blank), scaled by
//     S=SCALE_LOG2. dx=col-POS_X, dy=row-POS_Y, evaluated unsigned with explicit col>=POS_X,
//     row>=POS_Y checks (no wrap). in_box = dx < len_q*(8<<S) && dy < 7<<S.
//     idx = dx>>(3+S); gx = (dx>>S)&7; gy = dy>>S.
//   Glyph ROM: 32x49 bits, row-major MSB first: pixel (gy,gx) = glyph[48-(gy*7+gx)], gx<7.
//   Pipeline: S1 registers in_box, idx, gx, gy. S2 reads buffer[idx], ROM, visibility;
//     registers is_text and text_rgb. Latency exactly 2 clk; throughput 1 pixel/clk.
//   Visible = in_box && gx!=7 && glyph bit && idx<reveal_lim && blink_vis, where
//     reveal_lim = len_q for modes 00/01, reveal_cnt for 10/11;
//     blink_vis is forced 1 in modes 00/10 and in mode 11 until reveal_done.
//   start: len_q <= min(len, MAX_CHARS); mode_q <= mode; reveal_cnt <= 0; type/blink
//     counters <= 0; blink_vis <= 1. start wins over a coincident frame_tick (tick dropped).
//     start during an active reveal restarts it. len=0 -> nothing drawn, reveal_done=1.
//   Typewriter: on frame_tick, type_cnt++; at TYPE_FRAMES-1 wraps to 0 and reveal_cnt++
//     (saturates at len_q; counting stops when reveal_cnt==len_q).
//   Blink: on frame_tick (when blink active), blink_cnt++; at BLINK_FRAMES-1 wraps and
//     blink_vis toggles. Modes 00/10: counter held at 0.
//   Write: wr_en with wr_addr < MAX_CHARS updates buffer at clk edge; visible to S2 from the
//     next cycle. Out-of-range wr_addr ignored. Write and start in same cycle: both apply.
// TESTING
//   1 Reset: drive rst_n low mid-scan with text lit -> is_text=0, text_rgb=0, reveal_done=1
//     with no clk edge.
//   2 Static: write "HI" (8,9), start len=2 mode=00; H = 0100010/0100010/0100010/0111110/...
//     (col,row)=(POS_X+1,POS_Y) -> is_text=1, text_rgb=FFF 2 clk later; (POS_X+7,POS_Y) -> 0;
//     (POS_X+16,POS_Y) -> 0 (beyond len); (POS_X-1,POS_Y) -> 0 (no wrap).
//   3 Scale SCALE_LOG2=1, "H": (POS_X+2,POS_Y+1) -> 1 (gx=1,gy=0); (POS_X+4,POS_Y+6) -> 1
//     (gx=2,gy=3); (POS_X+14,POS_Y) -> 0 (gap col).
//   4 Typewriter mode=10, len=3: char1 hidden until 8th frame_tick, reveal_done rises after
//     12th tick; start on tick 6 resets reveal_cnt=0 and that tick is not counted.
//   5 Blink mode=01: text visible for frame_ticks 1..29, hidden 30..59, visible from 60;
//     mode=11 shows no blink until reveal_done.
//   6 Buffer: wr_addr=MAX_CHARS ignored (buffer unchanged); start len=40 -> len_q=MAX_CHARS.

Source files
------------

// File: rtl/text_banner.sv
// ---------------------------------------------------------------------------
// text_banner
//   On-screen text overlay for the VGA pixel path. Draws a runtime-writable
//   string of 7x7 glyphs inside a box whose top-left corner is (POS_X, POS_Y).
//   Glyphs can be magnified by 2**SCALE_LOG2. The display mode can be static,
//   blink, typewriter reveal, or typewriter reveal followed by blink.
//   The pixel output has a fixed latency of two clocks and accepts one pixel
//   per clock.
//
// Ports
//   clk, rst_n       pixel clock, asynchronous active-low reset
//   col, row         current scan position (10 bits each)
//   frame_tick       one-cycle pulse at the start of each frame
//   wr_en/wr_addr/   write one character code into the character buffer
//   wr_data            (0 = space, 1..26 = A..Z, 27..31 = blank)
//   start/len/mode   latch the string length and mode; restart reveal and blink
//   is_text          lit text pixel for the (col,row) seen two clocks earlier
//   text_rgb         COLOR when is_text is high, otherwise 12'h000
//   reveal_done      high while the revealed-character count equals the length
//
// There is no handshake: every input is sampled on every clock edge, and each
// output is valid on every cycle.
// ---------------------------------------------------------------------------
module text_banner #(
  parameter int          POS_X        = 8,
  parameter int          POS_Y        = 8,
  parameter int          MAX_CHARS    = 16,
  parameter int          SCALE_LOG2   = 0,
  parameter logic [11:0] COLOR        = 12'hFFF,
  parameter int          BLINK_FRAMES = 30,
  parameter int          TYPE_FRAMES  = 4,
  localparam int         AW           = $clog2(MAX_CHARS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    col,
  input  logic [9:0]    row,
  input  logic          frame_tick,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_data,
  input  logic          start,
  input  logic [5:0]    len,
  input  logic [1:0]    mode,
  output logic          is_text,
  output logic [11:0]   text_rgb,
  output logic          reveal_done
);

  localparam int TW     = (TYPE_FRAMES  > 1) ? $clog2(TYPE_FRAMES)  : 1;
  localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int CELL_H = 7 << SCALE_LOG2;

  // 7x7 font, row-major, MSB = top-left pixel. Codes 0 and 27..31 are blank.
  function automatic logic [48:0] glyph_rom(input logic [4:0] code);
    logic [48:0] g;
    case (code)
      5'd1:  g = {7'b0011100, 7'b0100010, 7'b0100010, 7'b0111110, 7'b0100010, 7'b0100010, 7'b0100010};
      5'd2:  g = {7'b0111100, 7'b0100010, 7'b0100010, 7'b0111100, 7'b0100010, 7'b0100010, 7'b0111100};
      5'd3:  g = {7'b0011110, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0011110};
      5'd4:  g = {7'b0111100, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0111100};
      5'd5:  g = {7'b0111110, 7'b0100000, 7'b0100000, 7'b0111100, 7'b0100000, 7'b0100000, 7'b0111110};
      5'd6:  g = {7'b0111110, 7'b0100000, 7'b0100000, 7'b0111100, 7'b0100000, 7'b0100000, 7'b0100000};
      5'd7:  g = {7'b0011110, 7'b0100000, 7'b0100000, 7'b0100110, 7'b0100010, 7'b0100010, 7'b0011110};
      5'd8:  g = {7'b0100010, 7'b0100010, 7'b0100010, 7'b0111110, 7'b0100010, 7'b0100010, 7'b0100010};
      5'd9:  g = {7'b0111110, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0111110};
      5'd10: g = {7'b0001110, 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100, 7'b0100100, 7'b0011000};
      5'd11: g = {7'b0100010, 7'b0100100, 7'b0101000, 7'b0110000, 7'b0101000, 7'b0100100, 7'b0100010};
      5'd12: g = {7'b0100000, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0111110};
      5'd13: g = {7'b0100010, 7'b0110110, 7'b0101010, 7'b0101010, 7'b0100010, 7'b0100010, 7'b0100010};
      5'd14: g = {7'b0100010, 7'b0110010, 7'b0101010, 7'b0100110, 7'b0100010, 7'b0100010, 7'b0100010};
      5'd15: g = {7'b0011100, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0011100};
      5'd16: g = {7'b0111100, 7'b0100010, 7'b0100010, 7'b0111100, 7'b0100000, 7'b0100000, 7'b0100000};
      5'd17: g = {7'b0011100, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0101010, 7'b0100100, 7'b0011010};
      5'd18: g = {7'b0111100, 7'b0100010, 7'b0100010, 7'b0111100, 7'b0101000, 7'b0100100, 7'b0100010};
      5'd19: g = {7'b0011110, 7'b0100000, 7'b0100000, 7'b0011100, 7'b0000010, 7'b0000010, 7'b0111100};
      5'd20: g = {7'b0111110, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000};
      5'd21: g = {7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0011100};
      5'd22: g = {7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0100010, 7'b0010100, 7'b0001000};
      5'd23: g = {7'b0100010, 7'b0100010, 7'b0100010, 7'b0101010, 7'b0101010, 7'b0110110, 7'b0100010};
      5'd24: g = {7'b0100010, 7'b0100010, 7'b0010100, 7'b0001000, 7'b0010100, 7'b0100010, 7'b0100010};
      5'd25: g = {7'b0100010, 7'b0100010, 7'b0010100, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000};
      5'd26: g = {7'b0111110, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000, 7'b0100000, 7'b0111110};
      default: g = '0;
    endcase
    return g;
  endfunction

  // ---------------- control state ----------------
  logic [4:0]    char_buf [MAX_CHARS];
  logic [5:0]    len_q;
  logic [1:0]    mode_q;
  logic [5:0]    reveal_cnt;
  logic [TW-1:0] type_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_vis;
  logic          blink_active;

  assign reveal_done = (reveal_cnt == len_q);

  // Mode 01 blinks at once; mode 11 only starts blinking after the reveal.
  assign blink_active = (mode_q == 2'b01) || ((mode_q == 2'b11) && reveal_done);

  // MAX_CHARS is a power of two, so every AW-bit address is a valid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CHARS; i++) char_buf[i] <= 5'd0;
    end else if (wr_en) begin
      char_buf[wr_addr] <= wr_data;
    end
  end

  // start has priority: a coincident frame_tick is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      mode_q     <= 2'b00;
      reveal_cnt <= '0;
      type_cnt   <= '0;
      blink_cnt  <= '0;
      blink_vis  <= 1'b1;
    end else if (start) begin
      len_q      <= (len > 6'(MAX_CHARS)) ? 6'(MAX_CHARS) : len;
      mode_q     <= mode;
      reveal_cnt <= '0;
      type_cnt   <= '0;
      blink_cnt  <= '0;
      blink_vis  <= 1'b1;
    end else if (frame_tick) begin
      // The typewriter stops counting once every character is shown.
      if (mode_q[1] && !reveal_done) begin
        if (type_cnt == TW'(TYPE_FRAMES - 1)) begin
          type_cnt   <= '0;
          reveal_cnt <= reveal_cnt + 6'd1;
        end else begin
          type_cnt <= type_cnt + TW'(1);
        end
      end
      if (blink_active) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_vis <= ~blink_vis;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        blink_cnt <= '0;
        blink_vis <= 1'b1;
      end
    end
  end

  // ---------------- stage 1: geometry ----------------
  logic [9:0]  dx, dy;
  logic [11:0] box_w;
  logic        in_box_c;

  assign dx    = col - 10'(POS_X);
  assign dy    = row - 10'(POS_Y);
  assign box_w = {6'd0, len_q} << (3 + SCALE_LOG2);
  // Explicit >= checks stop columns/rows left of or above the box from
  // wrapping around to large dx/dy values.
  assign in_box_c = (col >= 10'(POS_X)) && (row >= 10'(POS_Y)) &&
                    ({2'b00, dx} < box_w) && (dy < 10'(CELL_H));

  logic       in_box_s1;
  logic [5:0] idx_s1;
  logic [2:0] gx_s1, gy_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_s1 <= 1'b0;
      idx_s1    <= '0;
      gx_s1     <= '0;
      gy_s1     <= '0;
    end else begin
      in_box_s1 <= in_box_c;
      idx_s1    <= 6'(dx >> (3 + SCALE_LOG2));
      gx_s1     <= 3'(dx >> SCALE_LOG2);
      gy_s1     <= 3'(dy >> SCALE_LOG2);
    end
  end

  // ---------------- stage 2: glyph lookup and visibility ----------------
  logic [48:0] glyph_bits;
  logic [5:0]  bit_pos;
  logic [5:0]  reveal_lim;
  logic        lit;
  logic        vis;

  always_comb begin
    glyph_bits = glyph_rom(char_buf[idx_s1[AW-1:0]]);
    bit_pos    = ({3'b000, gy_s1} * 6'd7) + {3'b000, gx_s1};
    lit        = 1'b0;
    // Cell column 7 is the inter-character gap; gy 7 cannot occur in the box.
    if ((gx_s1 != 3'd7) && (gy_s1 != 3'd7)) lit = glyph_bits[6'd48 - bit_pos];
    reveal_lim = mode_q[1] ? reveal_cnt : len_q;
    vis        = in_box_s1 && lit && (idx_s1 < reveal_lim) &&
                 (!blink_active || blink_vis);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_text  <= 1'b0;
      text_rgb <= 12'h000;
    end else begin
      is_text  <= vis;
      text_rgb <= vis ? COLOR : 12'h000;
    end
  end

endmodule

// File: tb/tb_text_banner.sv
module tb_text_banner;

  localparam logic [11:0] COLOR = 12'hFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0]  col, row;
  logic        frame_tick, wr_en, start;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [5:0]  len;
  logic [1:0]  mode;
  logic        is_text0, is_text1, done0, done1;
  logic [11:0] rgb0, rgb1;

  text_banner u_dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row), .frame_tick(frame_tick),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .len(len), .mode(mode), .is_text(is_text0), .text_rgb(rgb0),
    .reveal_done(done0)
  );

  text_banner #(.SCALE_LOG2(1)) u_dut_x2 (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row), .frame_tick(frame_tick),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .len(len), .mode(mode), .is_text(is_text1), .text_rgb(rgb1),
    .reveal_done(done1)
  );

  // ---------------- scoreboard ----------------
  // Entry: {dut select, is_text, text_rgb}
  logic [13:0] exp_q[$];
  int          id_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        drv_valid;
  logic        v_d1, v_d2;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_d1 <= 1'b0;
      v_d2 <= 1'b0;
    end else begin
      v_d1 <= drv_valid;
      v_d2 <= v_d1;
    end
  end

  always @(negedge clk) begin
    if (v_d2) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 13'd1, 13'd0);
      end else begin
        logic [13:0] e;
        int          id;
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        if (e[13]) check($sformatf("pix%0d_x2", id), {is_text1, rgb1}, e[12:0]);
        else       check($sformatf("pix%0d", id), {is_text0, rgb0}, e[12:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_pix(input bit sel, input logic [9:0] c, input logic [9:0] r,
                           input bit lit, input int id);
    @(negedge clk);
    col = c; row = r; drv_valid = 1'b1;
    exp_q.push_back({sel, lit, lit ? COLOR : 12'h000});
    id_q.push_back(id);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drv_valid = 1'b0;
    end
  endtask

  task automatic check_pix(input logic [9:0] c, input logic [9:0] r, input bit lit, input int id);
    drive_pix(1'b0, c, r, lit, id);
    idle(3);
  endtask

  task automatic pulse(input bit do_wr, input logic [3:0] a, input logic [4:0] d,
                       input bit do_start, input logic [5:0] l, input logic [1:0] m,
                       input bit do_tick);
    @(negedge clk);
    drv_valid = 1'b0;
    wr_en = do_wr; wr_addr = a; wr_data = d;
    start = do_start; len = l; mode = m; frame_tick = do_tick;
    @(posedge clk);
    #1;
    wr_en = 1'b0; start = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [4:0] d);
    pulse(1'b1, a, d, 1'b0, 6'd0, 2'b00, 1'b0);
  endtask

  task automatic go(input logic [5:0] l, input logic [1:0] m);
    pulse(1'b0, 4'd0, 5'd0, 1'b1, l, m, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse(1'b0, 4'd0, 5'd0, 1'b0, 6'd0, 2'b00, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         sel;
    logic [9:0] c;
    logic [9:0] r;
    bit         lit;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  // ---------------- test ----------------
  initial begin
    int off;
    // "HI" at (8,8): H rows 0100010 x3 / 0111110 / 0100010 x3, I = 0111110 / 0001000 x5 / 0111110
    vecs[0]  = '{1'b0, 10'd9,  10'd8,  1'b1};  // H gx1 gy0
    vecs[1]  = '{1'b0, 10'd15, 10'd8,  1'b0};  // gap column
    vecs[2]  = '{1'b0, 10'd24, 10'd8,  1'b0};  // beyond len
    vecs[3]  = '{1'b0, 10'd7,  10'd8,  1'b0};  // left of box, no wrap
    vecs[4]  = '{1'b0, 10'd8,  10'd8,  1'b0};  // H gx0
    vecs[5]  = '{1'b0, 10'd13, 10'd8,  1'b1};  // H gx5
    vecs[6]  = '{1'b0, 10'd10, 10'd11, 1'b1};  // H crossbar gx2 gy3
    vecs[7]  = '{1'b0, 10'd10, 10'd10, 1'b0};  // H gx2 gy2
    vecs[8]  = '{1'b0, 10'd17, 10'd8,  1'b1};  // I gx1 gy0
    vecs[9]  = '{1'b0, 10'd19, 10'd10, 1'b1};  // I stem gx3 gy2
    vecs[10] = '{1'b0, 10'd17, 10'd10, 1'b0};  // I gx1 gy2
    vecs[11] = '{1'b0, 10'd9,  10'd15, 1'b0};  // below box
    vecs[12] = '{1'b0, 10'd9,  10'd7,  1'b0};  // above box, no wrap
    vecs[13] = '{1'b0, 10'd9,  10'd14, 1'b1};  // H gy6
    // x2 instance
    vecs[14] = '{1'b1, 10'd10, 10'd9,  1'b1};  // gx1 gy0
    vecs[15] = '{1'b1, 10'd12, 10'd14, 1'b1};  // gx2 gy3
    vecs[16] = '{1'b1, 10'd22, 10'd8,  1'b0};  // gap column
    vecs[17] = '{1'b1, 10'd8,  10'd8,  1'b0};  // gx0
    vecs[18] = '{1'b1, 10'd26, 10'd8,  1'b1};  // I gx1 gy0
    vecs[19] = '{1'b1, 10'd9,  10'd22, 1'b0};  // below scaled box
    vecs[20] = '{1'b1, 10'd10, 10'd21, 1'b1};  // H gx1 gy6

    rst_n = 1'b0; col = '0; row = '0; frame_tick = 1'b0; wr_en = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0; len = '0; mode = '0; drv_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_is_text", {12'd0, is_text0}, 13'd0);
    check("rst_rgb", {1'b0, rgb0}, 13'd0);
    check("rst_done", {12'd0, done0}, 13'd1);
    rst_n = 1'b1;

    // Static "HI", table applied back to back in a random rotation.
    wr(4'd0, 5'd8);
    wr(4'd1, 5'd9);
    go(6'd2, 2'b00);
    off = $urandom_range(0, NV - 1);
    for (int i = 0; i < NV; i++) begin
      int j;
      j = (i + off) % NV;
      drive_pix(vecs[j].sel, vecs[j].c, vecs[j].r, vecs[j].lit, j);
    end
    idle(3);

    // Empty string.
    go(6'd0, 2'b00);
    check("len0_done", {12'd0, done0}, 13'd1);
    check_pix(10'd9, 10'd8, 1'b0, 100);

    // Blink mode 01.
    go(6'd2, 2'b01);
    ticks(1);  check_pix(10'd9, 10'd8, 1'b1, 101);
    ticks(28); check_pix(10'd9, 10'd8, 1'b1, 102);
    ticks(1);  check_pix(10'd9, 10'd8, 1'b0, 103);
    ticks(29); check_pix(10'd9, 10'd8, 1'b0, 104);
    ticks(1);  check_pix(10'd9, 10'd8, 1'b1, 105);

    // Typewriter mode 10, "HIH".
    wr(4'd2, 5'd8);
    go(6'd3, 2'b10);
    check("tw_done_start", {12'd0, done0}, 13'd0);
    ticks(3);  check_pix(10'd9,  10'd8, 1'b0, 110);
    ticks(1);  check_pix(10'd9,  10'd8, 1'b1, 111);
    check_pix(10'd17, 10'd8, 1'b0, 112);
    ticks(3);  check_pix(10'd17, 10'd8, 1'b0, 113);
    ticks(1);  check_pix(10'd17, 10'd8, 1'b1, 114);
    ticks(3);  check("tw_done_t11", {12'd0, done0}, 13'd0);
    ticks(1);  check("tw_done_t12", {12'd0, done0}, 13'd1);
    check_pix(10'd25, 10'd8, 1'b1, 115);

    // Restart on the 6th tick: that tick must not count.
    go(6'd3, 2'b10);
    ticks(5);  check_pix(10'd9, 10'd8, 1'b1, 120);
    pulse(1'b0, 4'd0, 5'd0, 1'b1, 6'd3, 2'b10, 1'b1);
    check("restart_done", {12'd0, done0}, 13'd0);
    check_pix(10'd9, 10'd8, 1'b0, 121);
    ticks(3);  check_pix(10'd9, 10'd8, 1'b0, 122);
    ticks(1);  check_pix(10'd9, 10'd8, 1'b1, 123);

    // Mode 11: reveal first, blink counting starts only afterwards.
    go(6'd1, 2'b11);
    ticks(3);  check_pix(10'd9, 10'd8, 1'b0, 130);
    ticks(1);  check_pix(10'd9, 10'd8, 1'b1, 131);
    check("m11_done", {12'd0, done0}, 13'd1);
    ticks(26); check_pix(10'd9, 10'd8, 1'b1, 132);
    ticks(3);  check_pix(10'd9, 10'd8, 1'b1, 133);
    ticks(1);  check_pix(10'd9, 10'd8, 1'b0, 134);

    // len=40 clamps to 16 characters.
    for (int a = 0; a < 16; a++) wr(4'(a), 5'd8);
    go(6'd40, 2'b10);
    ticks(63); check("clamp_done_63", {12'd0, done0}, 13'd0);
    ticks(1);  check("clamp_done_64", {12'd0, done0}, 13'd1);
    check_pix(10'd129, 10'd8, 1'b1, 140);
    check_pix(10'd137, 10'd8, 1'b0, 141);

    // Asynchronous reset in the middle of a reveal with text lit.
    go(6'd2, 2'b10);
    ticks(4);
    check_pix(10'd9, 10'd8, 1'b1, 150);
    @(negedge clk);
    check("pre_rst_is_text", {12'd0, is_text0}, 13'd1);
    check("pre_rst_done", {12'd0, done0}, 13'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_is_text", {12'd0, is_text0}, 13'd0);
    check("async_rst_rgb", {1'b0, rgb0}, 13'd0);
    check("async_rst_done", {12'd0, done0}, 13'd1);
    exp_q.delete();
    id_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go(6'd1, 2'b00);
    check_pix(10'd9, 10'd8, 1'b0, 151);  // buffer cleared to space

    if (exp_q.size() != 0) check("scoreboard_leftover", 13'(exp_q.size()), 13'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
